// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback controller: request record,
// write-source select encoding and the address-to-onehot helper.
package rf_wb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_ALU,
    SEL_LD,
    SEL_FORCE_LD
  } wb_sel_e;

  function automatic logic [31:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    addr_onehot = 32'd1 << a;
  endfunction

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// ALU result, load result and RF write-port bundle of the writeback controller.
// The master modport is the controller's view; slave is the environment's.
interface rf_writeback_ctrl_if
  import rf_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_stall;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_addr;
  logic [XLEN-1:0]       ld_data;

  logic [XLEN-1:0]       rd;
  logic                  LoadRF;
  logic [REG_ADDR_W-1:0] rdAddr;

  modport master (
    input  alu_valid, alu_addr, alu_data,
    output alu_stall,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output rd, LoadRF, rdAddr
  );

  modport slave (
    output alu_valid, alu_addr, alu_data,
    input  alu_stall,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  rd, LoadRF, rdAddr
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Circular load queue of wb_req_t; also exposes per-entry valid bits and
// destination addresses so the parent can decode a pending-write mask.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output logic                                full,
  output logic                                empty,
  output logic [CW-1:0]                       count,
  output wb_req_t                             head,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_addr
);

  wb_req_t           mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [DEPTH-1:0]  vld;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];
  assign ent_valid = vld;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (do_push) begin
        wptr      <= wptr + PW'(1);
        vld[wptr] <= 1'b1;
      end
      if (do_pop) begin
        rptr      <= rptr + PW'(1);
        vld[rptr] <= 1'b0;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_req;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = mem[i].addr;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// RF write-side master: merges ALU results and queued loads onto one write port,
// ALU first, with an aging counter forcing a starved load. Option: WB_PENDING_EN.
module rf_writeback_ctrl
  import rf_wb_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int LQ_DEPTH = 4,
  parameter  int MAX_WAIT = 4,
  localparam int CW       = $clog2(LQ_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_writeback_ctrl_if.master  wb,
  output logic [CW-1:0]        lq_count,
  output logic [31:0]          pending_mask
);

  localparam int             WCW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  wb_sel_e                               sel;
  wb_req_t                               head;
  wb_req_t                               push_req;
  logic                                  alu_v;
  logic                                  push;
  logic                                  pop;
  logic                                  full;
  logic                                  empty;
  logic [WCW-1:0]                        wait_cnt;
  logic [LQ_DEPTH-1:0]                   ent_valid;
  logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0]   ent_addr;

  assign alu_v        = wb.alu_valid && (wb.alu_addr != '0);
  assign wb.ld_ready  = rst && !full;
  assign wb.alu_stall = rst && alu_v && (sel == SEL_FORCE_LD);
  assign push         = wb.ld_valid && wb.ld_ready && (wb.ld_addr != '0);
  assign pop          = (sel == SEL_LD) || (sel == SEL_FORCE_LD);
  assign push_req     = '{addr: wb.ld_addr, data: wb.ld_data};

  rf_wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (lq_count),
    .head      (head),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  // A head that has waited MAX_WAIT bypasses wins over the ALU.
  always_comb begin
    sel = SEL_IDLE;
    if (!empty && (wait_cnt >= WAIT_MAX)) begin
      sel = SEL_FORCE_LD;
    end else if (alu_v) begin
      sel = SEL_ALU;
    end else if (!empty) begin
      sel = SEL_LD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb.rd     <= '0;
      wb.rdAddr <= '0;
      wb.LoadRF <= 1'b0;
    end else begin
      case (sel)
        SEL_ALU: begin
          wb.rd     <= wb.alu_data;
          wb.rdAddr <= wb.alu_addr;
          wb.LoadRF <= 1'b1;
        end
        SEL_LD, SEL_FORCE_LD: begin
          wb.rd     <= head.data;
          wb.rdAddr <= head.addr;
          wb.LoadRF <= 1'b1;
        end
        default: begin
          wb.LoadRF <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (empty || pop) begin
      wait_cnt <= '0;
    end else if ((sel == SEL_ALU) && (wait_cnt < WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

`ifdef WB_PENDING_EN
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (ent_valid[i]) begin
        pending_mask = pending_mask | addr_onehot(ent_addr[i]);
      end
    end
    pending_mask[0] = 1'b0;
  end
`else
  logic unused_pending;
  assign pending_mask   = '0;
  assign unused_pending = ^{ent_valid, ent_addr};
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_rf_writeback_ctrl;
  import rf_wb_pkg::*;

  localparam int LQ_DEPTH = 4;
  localparam int MAX_WAIT = 4;
`ifdef WB_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  lq_count;
  logic [31:0] pending_mask;
  int          checks;
  int          errors;

  rf_writeback_ctrl_if #(.XLEN(32)) wbif ();

  rf_writeback_ctrl #(
    .XLEN     (32),
    .LQ_DEPTH (LQ_DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wbif),
    .lq_count     (lq_count),
    .pending_mask (pending_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: a plain queue of pending loads plus an integer age.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_wait;
  logic        m_load;
  logic [4:0]  m_addr;
  logic [31:0] m_rd;
  logic        m_stall;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_load;
    logic [4:0]  e_addr;
    logic [31:0] e_rd;
    logic        e_stall;
    logic [2:0]  e_cnt;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vecs[15];

  task automatic model_reset();
    mq.delete();
    m_wait  = 0;
    m_load  = 1'b0;
    m_addr  = '0;
    m_rd    = '0;
    m_stall = 1'b0;
  endtask

  task automatic model_eval(output logic stall, output logic ready, output int sel);
    logic aluv;
    aluv  = wbif.alu_valid && (wbif.alu_addr != 5'd0);
    ready = rst && (mq.size() < LQ_DEPTH);
    stall = 1'b0;
    if (mq.size() > 0 && m_wait >= MAX_WAIT) begin
      sel   = 2;
      stall = aluv;
    end else if (aluv) begin
      sel = 1;
    end else if (mq.size() > 0) begin
      sel = 2;
    end else begin
      sel = 0;
    end
  endtask

  task automatic model_clock();
    logic st;
    logic rdy;
    int   sel;
    int   was_size;
    ent_t h;
    model_eval(st, rdy, sel);
    was_size = mq.size();
    if (sel == 1) begin
      m_load = 1'b1;
      m_addr = wbif.alu_addr;
      m_rd   = wbif.alu_data;
    end else if (sel == 2) begin
      h      = mq.pop_front();
      m_load = 1'b1;
      m_addr = h.a;
      m_rd   = h.d;
    end else begin
      m_load = 1'b0;
    end
    if (was_size == 0 || sel == 2) begin
      m_wait = 0;
    end else if (sel == 1 && m_wait < MAX_WAIT) begin
      m_wait = m_wait + 1;
    end
    if (rdy && wbif.ld_valid && wbif.ld_addr != 5'd0) begin
      h.a = wbif.ld_addr;
      h.d = wbif.ld_data;
      mq.push_back(h);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].a] = 1'b1;
    m[0] = 1'b0;
    return PEND_EN ? m : 32'h0;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld);
    wbif.alu_valid = av;
    wbif.alu_addr  = aa;
    wbif.alu_data  = ad;
    wbif.ld_valid  = lv;
    wbif.ld_addr   = la;
    wbif.ld_data   = ld;
  endtask

  task automatic checkOutput(input string tag, input logic e_load, input logic [4:0] e_addr,
                             input logic [31:0] e_rd, input logic e_stall, input logic e_ready,
                             input logic [2:0] e_cnt, input logic [31:0] e_mask);
    check_val({tag, ".LoadRF"}, 32'(wbif.LoadRF), 32'(e_load));
    check_val({tag, ".rdAddr"}, 32'(wbif.rdAddr), 32'(e_addr));
    check_val({tag, ".rd"}, wbif.rd, e_rd);
    check_val({tag, ".alu_stall"}, 32'(wbif.alu_stall), 32'(e_stall));
    check_val({tag, ".ld_ready"}, 32'(wbif.ld_ready), 32'(e_ready));
    check_val({tag, ".lq_count"}, 32'(lq_count), 32'(e_cnt));
    check_val({tag, ".pending_mask"}, pending_mask, e_mask);
  endtask

  task automatic step(input string tag);
    logic st;
    logic rdy;
    int   sel;
    #1;
    model_eval(st, rdy, sel);
    checkOutput(tag, m_load, m_addr, m_rd, st, rdy, 3'(mq.size()), model_mask());
    m_stall = st;
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  logic [4:0] got[$];

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 5'h10, 32'hA,   1'b0, 5'h00, 32'h0,   1'b0, 5'h00, 32'h0,   1'b0, 3'd0, 32'h0};
    vecs[1]  = '{1'b1, 5'h00, 32'h55,  1'b0, 5'h00, 32'h0,   1'b1, 5'h10, 32'hA,   1'b0, 3'd0, 32'h0};
    vecs[2]  = '{1'b0, 5'h00, 32'h0,   1'b0, 5'h00, 32'h0,   1'b0, 5'h10, 32'hA,   1'b0, 3'd0, 32'h0};
    vecs[3]  = '{1'b0, 5'h00, 32'h0,   1'b1, 5'h11, 32'h9,   1'b0, 5'h10, 32'hA,   1'b0, 3'd0, 32'h0};
    vecs[4]  = '{1'b0, 5'h00, 32'h0,   1'b0, 5'h00, 32'h0,   1'b0, 5'h10, 32'hA,   1'b0, 3'd1, 32'h0002_0000};
    vecs[5]  = '{1'b0, 5'h00, 32'h0,   1'b0, 5'h00, 32'h0,   1'b1, 5'h11, 32'h9,   1'b0, 3'd0, 32'h0};
    vecs[6]  = '{1'b1, 5'h02, 32'h200, 1'b1, 5'h01, 32'h100, 1'b0, 5'h11, 32'h9,   1'b0, 3'd0, 32'h0};
    vecs[7]  = '{1'b1, 5'h03, 32'h300, 1'b0, 5'h00, 32'h0,   1'b1, 5'h02, 32'h200, 1'b0, 3'd1, 32'h2};
    vecs[8]  = '{1'b1, 5'h04, 32'h400, 1'b0, 5'h00, 32'h0,   1'b1, 5'h03, 32'h300, 1'b0, 3'd1, 32'h2};
    vecs[9]  = '{1'b1, 5'h05, 32'h500, 1'b0, 5'h00, 32'h0,   1'b1, 5'h04, 32'h400, 1'b0, 3'd1, 32'h2};
    vecs[10] = '{1'b1, 5'h06, 32'h600, 1'b0, 5'h00, 32'h0,   1'b1, 5'h05, 32'h500, 1'b0, 3'd1, 32'h2};
    vecs[11] = '{1'b1, 5'h07, 32'h700, 1'b0, 5'h00, 32'h0,   1'b1, 5'h06, 32'h600, 1'b1, 3'd1, 32'h2};
    vecs[12] = '{1'b1, 5'h07, 32'h700, 1'b0, 5'h00, 32'h0,   1'b1, 5'h01, 32'h100, 1'b0, 3'd0, 32'h0};
    vecs[13] = '{1'b0, 5'h00, 32'h0,   1'b0, 5'h00, 32'h0,   1'b1, 5'h07, 32'h700, 1'b0, 3'd0, 32'h0};
    vecs[14] = '{1'b0, 5'h00, 32'h0,   1'b0, 5'h00, 32'h0,   1'b0, 5'h07, 32'h700, 1'b0, 3'd0, 32'h0};

    rst = 1'b0;
    applyStimulus(1'b1, 5'h3, 32'h33, 1'b1, 5'h4, 32'h44);
    #1;
    checkOutput("reset", 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
    applyStimulus(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    #22 rst = 1'b1;
    model_reset();
    @(negedge clk);

    // Directed table: ALU only, x0 drop, idle-bus load latency, starvation.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e_load, vecs[i].e_addr, vecs[i].e_rd,
                  vecs[i].e_stall, 1'b1, vecs[i].e_cnt, PEND_EN ? vecs[i].e_mask : 32'h0);
      @(posedge clk);
      model_clock();
      @(negedge clk);
    end

    // Fill the queue behind a busy ALU, then watch the drain order.
    got.delete();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 5'h9, 32'h900 + 32'(c), 1'b1, 5'(c + 1), 32'h1000 + 32'(c));
      step("full_fill");
      if (wbif.LoadRF && wbif.rdAddr != 5'h9) got.push_back(wbif.rdAddr);
    end
    applyStimulus(1'b1, 5'h9, 32'h904, 1'b1, 5'h5, 32'h1005);
    #1;
    check_val("full_ready_low", 32'(wbif.ld_ready), 32'd0);
    check_val("full_count", 32'(lq_count), 32'd4);
    step("full_c4");
    applyStimulus(1'b1, 5'h9, 32'h905, 1'b1, 5'h5, 32'h1005);
    #1;
    check_val("full_force_stall", 32'(wbif.alu_stall), 32'd1);
    check_val("full_no_popthrough", 32'(wbif.ld_ready), 32'd0);
    step("full_c5");
    if (wbif.LoadRF && wbif.rdAddr != 5'h9) got.push_back(wbif.rdAddr);
    applyStimulus(1'b1, 5'h9, 32'h905, 1'b0, 5'h0, 32'h0);
    #1;
    check_val("full_ready_back", 32'(wbif.ld_ready), 32'd1);
    check_val("full_count_after_pop", 32'(lq_count), 32'd3);
    step("full_c6");
    if (wbif.LoadRF && wbif.rdAddr != 5'h9) got.push_back(wbif.rdAddr);
    applyStimulus(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      step("full_drain");
      if (wbif.LoadRF && wbif.rdAddr != 5'h9) got.push_back(wbif.rdAddr);
    end
    check_val("order_len", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("order%0d", i), (i < got.size()) ? 32'(got[i]) : 32'd0, 32'(i + 1));
    end

    // Asynchronous reset while three loads are queued.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 5'h9, 32'hA00 + 32'(c), 1'b1, 5'(c + 1), 32'h2000 + 32'(c));
      step("rst_fill");
    end
    applyStimulus(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    #1;
    check_val("pre_rst_count", 32'(lq_count), 32'd3);
    #1 rst = 1'b0;
    #1;
    checkOutput("midreset", 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
    #6 rst = 1'b1;
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      step("post_reset");
    end

    // Randomized traffic; a stalled ALU op is held until taken.
    for (int c = 0; c < 600; c++) begin
      if (!m_stall) begin
        wbif.alu_valid = ($urandom_range(0, 9) < 6);
        wbif.alu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        wbif.alu_data  = $urandom;
      end
      wbif.ld_valid = ($urandom_range(0, 1) == 1);
      wbif.ld_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wbif.ld_data  = $urandom;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
